ysyx_23060208_ifu: RTL and testbench
====================================

# ysyx_23060208_ifu

Instruction fetch unit: the stage directly upstream of the decode stage. It holds the architectural PC and issues one instruction-memory request at a time. It delivers `{pc, inst}` to decode through the valid/allowin handshake and retargets the PC when execute signals a redirect (jump, taken branch, ecall/mret). The block is a multi-cycle, single-outstanding-request fetcher with a one-entry output buffer.

## Interface
Parameters:
- `DATA_WIDTH`, 32: PC, address and instruction width.
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-low reset (asserted when 0).
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts the request.
- `imem_req_addr`  out  DATA_WIDTH: fetch address, always equal to the current PC.
- `imem_rsp_valid`  in  1: read data valid, one pulse per accepted request.
- `imem_rsp_data`  in  DATA_WIDTH: instruction word.
- `redirect_valid`  in  1: execute requests a PC change this cycle.
- `redirect_pc`  in  DATA_WIDTH: new PC.
- `ifu_to_idu_bus`  out  2*DATA_WIDTH: `{pc, inst}`, pc in the upper half.
- `ifu_to_idu_valid`  out  1: bus holds a valid instruction.
- `idu_allowin`  in  1: decode captures the bus this cycle.

## Operation
- States: IDLE, REQ, WAIT, OUT. Internal registers: `pc`, `inst_r`, `pc_r`, and a `discard` flag.
- IDLE: entered on reset; moves to REQ on the next clock.
- REQ: `imem_req_valid`=1. On `imem_req_ready` the FSM moves to WAIT.
- WAIT: waits for `imem_rsp_valid`.
  - If a response arrives with `discard`=0 and no redirect: `inst_r`<=data, `pc_r`<=pc, pc<=pc+4, move to OUT.
  - If a response arrives with `discard`=1 or a redirect in the same cycle: the data is dropped, `discard`<=0, move to REQ.
- OUT: `ifu_to_idu_valid`=1. When `idu_allowin`=1 the transfer completes and the FSM moves to REQ. While `idu_allowin`=0 the bus is held stable.
- Redirect has priority over every other event. It always sets pc<=`redirect_pc`. Per state:
  - REQ without handshake: stay in REQ. The address changes next cycle.
  - REQ with handshake in the same cycle: move to WAIT with `discard`<=1.
  - WAIT with no response: `discard`<=1, stay in WAIT.
  - OUT: the buffered instruction is dropped and valid falls. Move to REQ.
  - IDLE: the redirect is ignored.
- PC arithmetic: modulo 2^DATA_WIDTH. 32'hFFFF_FFFC+4 wraps to 0. No alignment check.
- `imem_rsp_valid` outside WAIT is ignored.

## Timing
- Reset values of outputs: `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `ifu_to_idu_valid`=0, `ifu_to_idu_bus`=0. Internal: `discard`=0, state IDLE.
- First request is asserted 1 cycle after reset release.
- Best-case throughput: 1 instruction every 3 cycles (REQ, WAIT, OUT) with zero-wait memory and `idu_allowin` held at 1.
- `ifu_to_idu_valid` rises the cycle after the response. It falls the cycle after a handshake or a redirect.
- Reset asserted mid-operation: all state clears immediately, whatever the state. A response still in flight is not tracked; memory is reset on the same reset net.
- All outputs are registered or decoded from state only. No combinational path from inputs to `imem_req_valid` or `ifu_to_idu_valid`.

## Configuration
- `YSYX_23060208_IFU_PERF_EN`: when defined, adds two outputs:
  - `perf_fetch_cnt` (32): counts completed IFU→IDU transfers.
  - `perf_wait_cycles` (32): counts cycles spent in WAIT.
  - Both counters reset to 0 and wrap on overflow.
- When the macro is undefined, neither port nor counter exists. Fetch behaviour is identical in both builds.

## Structure
- Shared header `ysyx_23060208_npc.h` holds:
  - `IFU_TO_IDU_BUS` width (64).
  - `RESET_PC` default.
  - the FSM state encoding, 2 bits: IDLE=0, REQ=1, WAIT=2, OUT=3.
- One sub-module, `ysyx_23060208_ifu_perf`: the two counters, instantiated only under the macro.

## Test plan
- Reset release, zero-wait memory returning 32'h0000_0013, `idu_allowin`=1:
  - request addresses 8000_0000, 8000_0004, 8000_0008 issued on cycles 1, 4, 7;
  - the bus carries `{8000_0000, 0000_0013}`.
- `idu_allowin` held 0 for 5 cycles in OUT: bus and valid remain stable. No new request until the handshake completes.
- Redirect to 8000_0100 while in WAIT, response arriving 3 cycles later: that response is dropped. Next request address is 8000_0100 and valid never rises for the old PC.
- Redirect to 8000_0200 in the same cycle as the REQ handshake: the old response is discarded and the next fetch is 8000_0200.
- Redirect to FFFF_FFFC, then one instruction delivered: pc_r = FFFF_FFFC and the next request address is 0000_0000.
- Reset pulled low while in OUT with valid=1: valid goes to 0 immediately. After release the first request is to RESET_PC. With the PERF macro defined, both counters read 0.

Source files
------------

// File: rtl/ysyx_23060208_ifu_pkg.sv
// Shared IFU definitions: data/bus widths, reset PC default and fetch FSM encoding.
package ysyx_23060208_ifu_pkg;

    localparam int          IFU_DATA_WIDTH = 32;
    localparam int          IFU_TO_IDU_BUS = 2 * IFU_DATA_WIDTH;
    localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ysyx_23060208_ifu_perf.sv
// IFU performance counters: completed IFU->IDU transfers and cycles spent waiting on memory.
module ysyx_23060208_ifu_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_done,
    input  logic        in_wait,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_wait_cycles
);

    logic [31:0] fetch_cnt_reg;
    logic [31:0] wait_cnt_reg;

    // Both counters wrap silently on overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_reg <= 32'd0;
            wait_cnt_reg  <= 32'd0;
        end else begin
            if (fetch_done) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (in_wait) begin
                wait_cnt_reg <= wait_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt   = fetch_cnt_reg;
    assign perf_wait_cycles = wait_cnt_reg;

endmodule

// File: rtl/ysyx_23060208_ifu.sv
// Single-outstanding-request instruction fetcher with a one-entry output buffer toward decode.
// Define YSYX_23060208_IFU_PERF_EN to add the perf_fetch_cnt / perf_wait_cycles counters.
module ysyx_23060208_ifu
    import ysyx_23060208_ifu_pkg::*;
#(
    parameter int                    DATA_WIDTH = IFU_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [DATA_WIDTH-1:0]   imem_req_addr,
    input  logic                    imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   imem_rsp_data,
    input  logic                    redirect_valid,
    input  logic [DATA_WIDTH-1:0]   redirect_pc,
    output logic [2*DATA_WIDTH-1:0] ifu_to_idu_bus,
    output logic                    ifu_to_idu_valid,
    input  logic                    idu_allowin
`ifdef YSYX_23060208_IFU_PERF_EN
    ,
    output logic [31:0]             perf_fetch_cnt,
    output logic [31:0]             perf_wait_cycles
`endif
);

    ifu_state_e            state_reg;
    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] pc_r_reg;
    logic [DATA_WIDTH-1:0] inst_r_reg;
    logic                  discard_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= RESET_PC;
            pc_r_reg    <= '0;
            inst_r_reg  <= '0;
            discard_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_REQ;
                end
                ST_REQ: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_pc;
                    end
                    // A request already accepted for the stale PC must have its data dropped.
                    if (imem_req_ready) begin
                        state_reg   <= ST_WAIT;
                        discard_reg <= redirect_valid;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_pc;
                    end
                    if (imem_rsp_valid) begin
                        if (discard_reg || redirect_valid) begin
                            discard_reg <= 1'b0;
                            state_reg   <= ST_REQ;
                        end else begin
                            inst_r_reg <= imem_rsp_data;
                            pc_r_reg   <= pc_reg;
                            pc_reg     <= pc_reg + DATA_WIDTH'(4);
                            state_reg  <= ST_OUT;
                        end
                    end else if (redirect_valid) begin
                        discard_reg <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (redirect_valid) begin
                        pc_reg    <= redirect_pc;
                        state_reg <= ST_REQ;
                    end else if (idu_allowin) begin
                        state_reg <= ST_REQ;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid   = (state_reg == ST_REQ);
    assign imem_req_addr    = pc_reg;
    assign ifu_to_idu_valid = (state_reg == ST_OUT);
    assign ifu_to_idu_bus   = {pc_r_reg, inst_r_reg};

`ifdef YSYX_23060208_IFU_PERF_EN
    logic fetch_done;
    assign fetch_done = (state_reg == ST_OUT) && idu_allowin && !redirect_valid;

    ysyx_23060208_ifu_perf u_perf (
        .clk              (clk),
        .rst              (rst),
        .fetch_done       (fetch_done),
        .in_wait          (state_reg == ST_WAIT),
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_wait_cycles (perf_wait_cycles)
    );
`endif

endmodule

// File: tb/tb_ysyx_23060208_ifu.sv
// Directed plus randomized bench for ysyx_23060208_ifu against a transaction-level PC/instruction model.
`timescale 1ns/1ps
module tb_ysyx_23060208_ifu;
    import ysyx_23060208_ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      imem_req_valid;
    logic                      imem_req_ready = 1'b0;
    logic [31:0]               imem_req_addr;
    logic                      imem_rsp_valid = 1'b0;
    logic [31:0]               imem_rsp_data  = 32'd0;
    logic                      redirect_valid = 1'b0;
    logic [31:0]               redirect_pc    = 32'd0;
    logic [IFU_TO_IDU_BUS-1:0] ifu_to_idu_bus;
    logic                      ifu_to_idu_valid;
    logic                      idu_allowin    = 1'b0;
`ifdef YSYX_23060208_IFU_PERF_EN
    logic [31:0]               perf_fetch_cnt;
    logic [31:0]               perf_wait_cycles;
`endif

    ysyx_23060208_ifu dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .ifu_to_idu_bus   (ifu_to_idu_bus),
        .ifu_to_idu_valid (ifu_to_idu_valid),
        .idu_allowin      (idu_allowin)
`ifdef YSYX_23060208_IFU_PERF_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    // Memory model: one accepted request in flight, answered after mem_dly cycles.
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    int          mem_dly  = 0;
    int          mem_lat  = 0;
    bit          rand_mode = 1'b0;
    // Reference model: PC of the next instruction decode should receive.
    logic [31:0] exp_pc = RST_PC;
    int          n_deliv = 0;
    int          n_since_rst = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a - 32'h8000_0000 + 32'h13;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return imem_req_valid;
            1:       return ifu_to_idu_valid;
            default: return mem_pend;
        endcase
    endfunction

    // Called at a negedge with inputs set; advances one clock and returns at the next negedge.
    task automatic cycle();
        bit          acc;
        bit          rsp;
        bit          dlv;
        bit          hold;
        logic [31:0] acc_addr;
        logic [63:0] bus_prev;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        rsp      = imem_rsp_valid;
        dlv      = ifu_to_idu_valid && idu_allowin && !redirect_valid;
        hold     = ifu_to_idu_valid && !idu_allowin && !redirect_valid;
        bus_prev = ifu_to_idu_bus;
        if (dlv) begin
            check("deliver_bus", ifu_to_idu_bus, {exp_pc, inst_of(exp_pc)});
            n_deliv++;
            n_since_rst++;
            $display("xfer %0d pc=%h inst=%h", n_deliv, ifu_to_idu_bus[63:32], ifu_to_idu_bus[31:0]);
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) exp_pc = redirect_pc;
        @(posedge clk);
        if (rsp) mem_pend = 1'b0;
        if (acc) begin
            mem_pend = 1'b1;
            mem_addr = acc_addr;
            mem_dly  = rand_mode ? int'($urandom_range(0, 3)) : mem_lat;
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        if (hold) begin
            check("hold_valid", ifu_to_idu_valid, 1);
            check("hold_bus", ifu_to_idu_bus, bus_prev);
        end
        if (mem_pend && mem_dly == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mem_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
            if (mem_pend) mem_dly--;
        end
        if (rand_mode) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            idu_allowin    = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic wait_for(input string tag, input int which, input int budget);
        int n;
        n = 0;
        while (!cond(which) && n < budget) begin
            cycle();
            n++;
        end
        check(tag, cond(which), 1);
    endtask

    // Holds reset for two cycles, checks reset values, releases at a negedge (cycle 0).
    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        mem_pend       = 1'b0;
        exp_pc         = RST_PC;
        n_since_rst    = 0;
        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_out_valid", ifu_to_idu_valid, 0);
        check("rst_bus", ifu_to_idu_bus, 0);
`ifdef YSYX_23060208_IFU_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 0);
        check("rst_perf_wait", perf_wait_cycles, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit          saw;
        int          n;
        int          base;
        logic [63:0] snap;

        // 1: zero-wait memory, decode always ready -> one fetch every 3 cycles.
        imem_req_ready = 1'b1;
        idu_allowin    = 1'b1;
        mem_lat        = 0;
        do_reset();
        check("c0_req_valid", imem_req_valid, 0);
        for (int i = 1; i <= 7; i++) begin
            cycle();
            if (i % 3 == 1) begin
                check("tp_req_valid", imem_req_valid, 1);
                check("tp_req_addr", imem_req_addr, RST_PC + 32'(4 * ((i - 1) / 3)));
            end else begin
                check("tp_req_quiet", imem_req_valid, 0);
            end
            if (i == 3) check("tp_first_bus", ifu_to_idu_bus, {32'h8000_0000, 32'h0000_0013});
        end

        // 2: decode stalls for 5 cycles in OUT.
        idu_allowin = 1'b0;
        wait_for("stall_reach_out", 1, 10);
        snap = ifu_to_idu_bus;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_valid", ifu_to_idu_valid, 1);
            check("stall_bus", ifu_to_idu_bus, snap);
            check("stall_no_req", imem_req_valid, 0);
        end
        idu_allowin = 1'b1;
        cycle();
        check("stall_release_valid", ifu_to_idu_valid, 0);
        check("stall_release_req", imem_req_valid, 1);

        // 3: redirect while waiting; stale response lands 3 cycles later.
        mem_lat = 3;
        wait_for("wait_reach", 2, 10);
        mem_lat        = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        cycle();
        saw = 1'b0;
        n   = 0;
        while (!imem_req_valid && n < 20) begin
            if (ifu_to_idu_valid) saw = 1'b1;
            cycle();
            n++;
        end
        check("wredir_no_valid", saw, 0);
        check("wredir_req_addr", imem_req_addr, 32'h8000_0100);
        wait_for("wredir_out", 1, 10);
        check("wredir_bus_pc", ifu_to_idu_bus[63:32], 32'h8000_0100);

        // 4: redirect coinciding with the request handshake.
        wait_for("hsredir_req", 0, 10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        cycle();
        check("hsredir_in_wait", imem_req_valid, 0);
        wait_for("hsredir_req2", 0, 10);
        check("hsredir_addr", imem_req_addr, 32'h8000_0200);
        wait_for("hsredir_out", 1, 10);
        check("hsredir_bus_pc", ifu_to_idu_bus[63:32], 32'h8000_0200);

        // 5: PC wraps past the top of the address space.
        wait_for("wrap_req", 0, 10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        wait_for("wrap_out", 1, 10);
        check("wrap_bus_pc", ifu_to_idu_bus[63:32], 32'hFFFF_FFFC);
        cycle();
        wait_for("wrap_req2", 0, 10);
        check("wrap_next_addr", imem_req_addr, 32'h0000_0000);

        // 6: asynchronous reset while holding an instruction.
        idu_allowin = 1'b0;
        wait_for("arst_out", 1, 10);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid_drop", ifu_to_idu_valid, 0);
        check("arst_req_drop", imem_req_valid, 0);
        check("arst_bus_clear", ifu_to_idu_bus, 0);
        @(negedge clk);
        idu_allowin = 1'b1;
        do_reset();
        cycle();
        check("arst_first_req", imem_req_valid, 1);
        check("arst_first_addr", imem_req_addr, RST_PC);

        // 7: random ready/allowin/latency with occasional redirects.
        rand_mode = 1'b1;
        base      = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            end
            cycle();
        end
        check("rand_progress", (n_deliv - base) > 100, 1);
`ifdef YSYX_23060208_IFU_PERF_EN
        check("perf_fetch_total", perf_fetch_cnt, 64'(n_since_rst));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
